// File: rtl/modular_exponentiation_pkg.sv
// Shared encodings for the modular exponentiation block and the multiplier stage beside it.
package modular_exponentiation_pkg;

  localparam int DEFAULT_SIZE = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_RED = 2'd0,
    OP_MUL = 2'd1,
    OP_SQR = 2'd2
  } op_e;

endpackage

// File: rtl/modular_exponentiation.sv
// Right-to-left square-and-multiply base^exp mod m; every product is delegated
// to an external modular multiplier over an AXI-stream request/result pair.
module modular_exponentiation
  import modular_exponentiation_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in_tdata_base,
  input  logic [SIZE-1:0] in_tdata_exp,
  input  logic [SIZE-1:0] in_tdata_mod,
  input  logic            in_tvalid,
  output logic            in_tready,
  output logic [SIZE-1:0] mm_a_tdata,
  output logic [SIZE-1:0] mm_b_tdata,
  output logic [SIZE-1:0] mm_mod_tdata,
  output logic            mm_tvalid,
  input  logic            mm_tready,
  input  logic [SIZE-1:0] mm_res_tdata,
  input  logic            mm_res_tvalid,
  output logic            mm_res_tready,
  output logic [SIZE-1:0] out_tdata,
  output logic            out_tvalid,
  input  logic            out_tready
);

  localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [SIZE-1:0] acc_q, acc_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [SIZE-1:0] e_q, e_d;
  logic [SIZE-1:0] m_q, m_d;
  logic [SIZE-1:0] e_shr;
  logic [SIZE-1:0] opa, opb;

  assign e_shr = e_q >> 1;

  // Control state is reset; the datapath registers are only meaningful once a job is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RED;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    b_q   <= b_d;
    e_q   <= e_d;
    m_q   <= m_d;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    b_d     = b_q;
    e_d     = e_q;
    m_d     = m_q;
    case (state_q)
      ST_IDLE: begin
        if (in_tvalid) begin
          b_d = in_tdata_base;
          e_d = in_tdata_exp;
          m_d = in_tdata_mod;
          if (in_tdata_mod <= ONE) begin
            acc_d   = '0;
            state_d = ST_DONE;
          end else begin
            // First product base*1 reduces a base that may be >= m.
            acc_d   = ONE;
            op_d    = OP_RED;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mm_tready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mm_res_tvalid) begin
          if (op_q == OP_MUL) begin
            acc_d = mm_res_tdata;
            e_d   = e_shr;
            if (e_shr != '0) begin
              op_d    = OP_SQR;
              state_d = ST_REQ;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            b_d     = mm_res_tdata;
            state_d = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        if (e_q == '0) begin
          state_d = ST_DONE;
        end else if (e_q[0]) begin
          op_d    = OP_MUL;
          state_d = ST_REQ;
        end else begin
          e_d = e_shr;
          if (e_shr != '0) begin
            op_d    = OP_SQR;
            state_d = ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_tready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    opa = (op_q == OP_MUL) ? acc_q : b_q;
    opb = (op_q == OP_RED) ? ONE : b_q;
  end

  // Data outputs are forced to zero outside the state that qualifies them.
  assign mm_tvalid     = (state_q == ST_REQ);
  assign mm_a_tdata    = mm_tvalid ? opa : '0;
  assign mm_b_tdata    = mm_tvalid ? opb : '0;
  assign mm_mod_tdata  = mm_tvalid ? m_q : '0;
  assign mm_res_tready = (state_q == ST_WAIT);
  assign out_tvalid    = (state_q == ST_DONE);
  assign out_tdata     = out_tvalid ? acc_q : '0;
  assign in_tready     = (state_q == ST_IDLE) & ~rst;

endmodule

// File: tb/tb_modular_exponentiation.sv
// Scoreboard bench: jobs push expected results, a monitor checks each output
// handshake; a behavioural multiplier answers mm requests with random latency.
module tb_modular_exponentiation;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_tdata_base, in_tdata_exp, in_tdata_mod;
  logic         in_tvalid, in_tready;
  logic [W-1:0] mm_a_tdata, mm_b_tdata, mm_mod_tdata;
  logic         mm_tvalid, mm_tready;
  logic [W-1:0] mm_res_tdata;
  logic         mm_res_tvalid, mm_res_tready;
  logic [W-1:0] out_tdata;
  logic         out_tvalid, out_tready;

  modular_exponentiation #(.SIZE(W)) dut (
    .clk(clk), .rst(rst),
    .in_tdata_base(in_tdata_base), .in_tdata_exp(in_tdata_exp), .in_tdata_mod(in_tdata_mod),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .mm_a_tdata(mm_a_tdata), .mm_b_tdata(mm_b_tdata), .mm_mod_tdata(mm_mod_tdata),
    .mm_tvalid(mm_tvalid), .mm_tready(mm_tready),
    .mm_res_tdata(mm_res_tdata), .mm_res_tvalid(mm_res_tvalid), .mm_res_tready(mm_res_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           ntx;
    int           base_cnt;
    string        name;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           txn_cnt  = 0;
  int           mm_stall = 0;
  int           out_stall = 0;
  logic [W-1:0] log_a[$], log_b[$];

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Golden model: left-to-right exponentiation with wide plain arithmetic.
  function automatic logic [W-1:0] ref_pow(logic [W-1:0] b, logic [W-1:0] e, logic [W-1:0] m);
    logic [127:0] r, bb;
    if (m <= 1) return '0;
    bb = 128'(b) % 128'(m);
    r  = 128'd1;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % 128'(m);
      if (e[i]) r = (r * bb) % 128'(m);
    end
    return r[W-1:0];
  endfunction

  function automatic int ref_ntx(logic [W-1:0] e, logic [W-1:0] m);
    int bl;
    if (m <= 1) return 0;
    if (e == '0) return 1;
    bl = 0;
    for (int i = 0; i < W; i++) if (e[i]) bl = i + 1;
    return 1 + $countones(e) + bl - 1;
  endfunction

  // Behavioural modular multiplier with random ready and result latency.
  initial begin : mm_model
    logic [127:0] prod;
    logic [W-1:0] ca, cb, cm;
    int           lat;
    bit           pend, hs_req, hs_res;
    pend = 0; lat = 0; prod = '0;
    mm_tready = 1'b0; mm_res_tvalid = 1'b0; mm_res_tdata = '0;
    forever begin
      @(negedge clk);
      if (mm_stall > 0) begin
        mm_tready = 1'b0;
        if (mm_tvalid) mm_stall--;
      end else begin
        mm_tready = ($urandom_range(0, 3) != 0);
      end
      if (pend) begin
        if (!mm_res_tvalid) begin
          if (lat > 0) lat--;
          else begin
            mm_res_tvalid = 1'b1;
            mm_res_tdata  = prod[W-1:0];
          end
        end
      end else begin
        // Stray results while no request is outstanding must be ignored.
        mm_res_tvalid = ($urandom_range(0, 7) == 0);
        mm_res_tdata  = {$urandom, $urandom};
      end
      hs_req = mm_tvalid && mm_tready;
      hs_res = mm_res_tvalid && mm_res_tready;
      ca = mm_a_tdata; cb = mm_b_tdata; cm = mm_mod_tdata;
      @(posedge clk);
      #1;
      if (rst) begin
        pend = 0;
        mm_res_tvalid = 1'b0;
      end else begin
        if (hs_res) begin
          mm_res_tvalid = 1'b0;
          pend = 0;
        end
        if (hs_req) begin
          prod = (cm == '0) ? 128'd0 : (128'(ca) * 128'(cb)) % 128'(cm);
          txn_cnt++;
          log_a.push_back(ca);
          log_b.push_back(cb);
          lat  = $urandom_range(0, 3);
          pend = 1;
          mm_res_tvalid = 1'b0;
        end
      end
    end
  end

  initial begin : out_drv
    out_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_stall > 0) begin
        out_tready = 1'b0;
        if (out_tvalid) out_stall--;
      end else begin
        out_tready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin : monitor
    exp_t         x;
    logic         prev_ov, prev_mv;
    logic [W-1:0] prev_od, prev_a, prev_b, prev_m;
    prev_ov = 1'b0; prev_mv = 1'b0;
    prev_od = '0; prev_a = '0; prev_b = '0; prev_m = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_ov = 1'b0;
        prev_mv = 1'b0;
        continue;
      end
      if (prev_ov) begin
        check("out_hold_valid", W'(out_tvalid), W'(1));
        check("out_hold_data", out_tdata, prev_od);
      end
      if (prev_mv) begin
        check("mm_hold_valid", W'(mm_tvalid), W'(1));
        check("mm_hold_a", mm_a_tdata, prev_a);
        check("mm_hold_b", mm_b_tdata, prev_b);
        check("mm_hold_mod", mm_mod_tdata, prev_m);
      end
      if (sb.size() != 0 && (out_tvalid || mm_tvalid)) check("in_tready_busy", W'(in_tready), W'(0));
      if (out_tvalid && out_tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_unexpected: got result %0h with no job pending", out_tdata);
        end else begin
          x = sb.pop_front();
          check({x.name, "_result"}, out_tdata, x.res);
          check({x.name, "_txns"}, W'(txn_cnt - x.base_cnt), W'(x.ntx));
        end
      end
      prev_ov = out_tvalid && !out_tready;
      prev_od = out_tdata;
      prev_mv = mm_tvalid && !mm_tready;
      prev_a = mm_a_tdata; prev_b = mm_b_tdata; prev_m = mm_mod_tdata;
    end
  end

  task automatic run_job(string name, logic [W-1:0] b, logic [W-1:0] e, logic [W-1:0] m);
    exp_t x;
    int   t;
    @(negedge clk);
    in_tdata_base = b; in_tdata_exp = e; in_tdata_mod = m;
    in_tvalid = 1'b1;
    t = 0;
    while (!in_tready) begin
      t++;
      if (t > 20000) begin
        n_checks++; n_fail++;
        $display("FAIL %s_accept: in_tready stayed 0, expected 1 within 20000 cycles", name);
        in_tvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
    x.res = ref_pow(b, e, m);
    x.ntx = ref_ntx(e, m);
    x.base_cnt = txn_cnt;
    x.name = name;
    sb.push_back(x);
  endtask

  task automatic wait_done(string name);
    int t;
    t = 0;
    while (sb.size() != 0) begin
      t++;
      if (t > 20000) begin
        n_checks++; n_fail++;
        $display("FAIL %s_done: result pending after 20000 cycles, expected delivery", name);
        sb.delete();
        return;
      end
      @(posedge clk);
    end
    @(posedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation still running at 90000 cycles, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [W-1:0] ea[5], eb[5];
    logic [W-1:0] rb, re, rm;
    int           t, base;
    bit           seen;
    rst = 1'b1;
    in_tvalid = 1'b0; in_tdata_base = '0; in_tdata_exp = '0; in_tdata_mod = '0;
    #1;
    check("rst_in_tready", W'(in_tready), W'(0));
    check("rst_mm_tvalid", W'(mm_tvalid), W'(0));
    check("rst_mm_res_tready", W'(mm_res_tready), W'(0));
    check("rst_out_tvalid", W'(out_tvalid), W'(0));
    check("rst_out_tdata", out_tdata, '0);
    check("rst_mm_a", mm_a_tdata, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_in_tready", W'(in_tready), W'(1));

    // 3^5 mod 7 with the exact operand sequence RED, MUL, SQR, SQR, MUL.
    log_a.delete(); log_b.delete();
    ea = '{64'd3, 64'd1, 64'd3, 64'd2, 64'd3};
    eb = '{64'd1, 64'd3, 64'd3, 64'd2, 64'd4};
    run_job("p3_5_7", 64'd3, 64'd5, 64'd7);
    wait_done("p3_5_7");
    check("seq_len", W'(log_a.size()), W'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < log_a.size()) begin
        check($sformatf("seq_a%0d", i), log_a[i], ea[i]);
        check($sformatf("seq_b%0d", i), log_b[i], eb[i]);
      end
    end

    run_job("p2_10_1000", 64'd2, 64'd10, 64'd1000);
    run_job("p1234_1_97", 64'd1234, 64'd1, 64'd97);
    run_job("exp0_13", 64'd123456, 64'd0, 64'd13);
    wait_done("directed");

    // Degenerate moduli: no multiplier traffic, quick result.
    for (int k = 0; k < 2; k++) begin
      rb = {$urandom, $urandom}; re = {$urandom, $urandom};
      rm = W'(k);
      base = txn_cnt;
      run_job($sformatf("mod%0d", k), rb, re, rm);
      seen = 1'b0;
      for (int c = 0; c < 2 && !seen; c++) begin
        if (out_tvalid) seen = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      check($sformatf("mod%0d_latency", k), W'(seen), W'(1));
      wait_done("mod_small");
      check($sformatf("mod%0d_no_mm", k), W'(txn_cnt - base), W'(0));
    end

    // Backpressure on both the request and the output channel.
    mm_stall = 10;
    out_stall = 5;
    run_job("bp", 64'd7, 64'd13, 64'd101);
    wait_done("bp");
    check("bp_mm_stall_used", W'(mm_stall), W'(0));
    check("bp_out_stall_used", W'(out_stall), W'(0));

    // Abort during the wait for the third product.
    run_job("abort", {$urandom, $urandom}, {W{1'b1}}, {1'b1, 31'($urandom), $urandom});
    base = sb.size() != 0 ? sb[0].base_cnt : txn_cnt;
    t = 0;
    @(negedge clk);
    while (!((txn_cnt - base) == 3 && mm_res_tready) && t < 2000) begin
      t++;
      @(negedge clk);
    end
    check("abort_reached_wait3", W'(t < 2000), W'(1));
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_mm_tvalid", W'(mm_tvalid), W'(0));
    check("abort_mm_res_tready", W'(mm_res_tready), W'(0));
    check("abort_out_tvalid", W'(out_tvalid), W'(0));
    check("abort_in_tready", W'(in_tready), W'(0));
    check("abort_mm_a", mm_a_tdata, '0);
    check("abort_mm_b", mm_b_tdata, '0);
    check("abort_mm_mod", mm_mod_tdata, '0);
    check("abort_out_tdata", out_tdata, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_rel_in_tready", W'(in_tready), W'(1));
    run_job("p5_3_13", 64'd5, 64'd3, 64'd13);
    wait_done("p5_3_13");

    run_job("all_ones_exp", {$urandom, $urandom}, {W{1'b1}}, {1'b1, 31'($urandom), $urandom});
    wait_done("all_ones_exp");

    for (int j = 0; j < 30; j++) begin
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: re = W'($urandom_range(0, 255));
        1: re = {W{1'b1}};
        default: re = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0: rm = W'($urandom_range(2, 1000));
        1: rm = {1'b1, 31'($urandom), $urandom};
        2: rm = W'($urandom_range(0, 1));
        default: rm = {$urandom, $urandom};
      endcase
      run_job($sformatf("rnd%0d", j), rb, re, rm);
    end
    wait_done("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
